// File: rtl/button_event_pkg.sv
// Shared types for the button event block: event codes, per-port FSM states
// and the event payload that travels through the output FIFO.
package button_event_pkg;

  localparam int unsigned CODE_W     = 2;
  localparam int unsigned EVT_PORT_W = 8;

  typedef enum logic [CODE_W-1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } event_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2
  } btn_state_t;

  typedef struct packed {
    event_code_t           code;
    logic [EVT_PORT_W-1:0] port;
  } event_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_fifo.sv
// Show-ahead synchronous FIFO of key events; push is accepted at full when a
// pop happens in the same cycle.
module button_event_fifo
  import button_event_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_push,
  input  event_t i_data,
  input  logic   i_pop,
  output event_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = AW + 1;

  event_t           r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_head  = r_mem[r_rd];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_rd_en) r_rd <= r_rd + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/button_event.sv
// Turns debounced switch levels into PRESS/RELEASE/LONG/REPEAT events and
// serializes them from all ports into one valid/ready stream.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned CLOCK_HZ         = 12_000_000,
  parameter int unsigned TICK_HZ          = 1000,
  parameter int unsigned PORT_BITS        = 1,
  parameter int unsigned LONG_PRESS_TICKS = 500,
  parameter int unsigned REPEAT_TICKS     = 100,
  parameter int unsigned FIFO_DEPTH       = 4,
  localparam int unsigned PW = (PORT_BITS > 1) ? $clog2(PORT_BITS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [PORT_BITS-1:0] sync_in,
  output logic [PORT_BITS-1:0] pressed,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [1:0]           event_code,
  output logic [PW-1:0]        event_port,
  output logic                 overflow,
  input  logic                 overflow_clear
);

  localparam int unsigned DIV      = CLOCK_HZ / TICK_HZ;
  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HOLD_MAX = max_u(LONG_PRESS_TICKS, REPEAT_TICKS);
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX);

  logic [DIV_W-1:0]     r_div;
  logic                 w_tick;
  logic [PORT_BITS-1:0] r_prev;
  logic [PORT_BITS-1:0] w_rise;
  logic [PORT_BITS-1:0] w_fall;
  logic [PORT_BITS-1:0] w_slot_v;
  logic [PORT_BITS-1:0] w_grant;
  logic [PORT_BITS-1:0] w_drain;
  logic [PORT_BITS-1:0] w_drop;
  event_code_t          w_slot_code [PORT_BITS];
  logic                 w_any;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  event_t               w_push_data;
  event_t               w_head;
  logic                 r_overflow;
  logic                 w_unused_port;

  // Free-running tick divider; tick fires on count zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        r_div <= '0;
    else if (r_div == DIV_W'(DIV - 1))   r_div <= '0;
    else                                 r_div <= r_div + DIV_W'(1);
  end
  assign w_tick = (r_div == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_prev <= '0;
    else          r_prev <= sync_in;
  end
  assign pressed = r_prev;
  assign w_rise  = sync_in & ~r_prev;
  assign w_fall  = ~sync_in & r_prev;

  for (genvar gi = 0; gi < PORT_BITS; gi++) begin : g_port
    btn_state_t        r_state;
    btn_state_t        w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_post;
    event_code_t       w_post_code;
    logic              r_v;
    event_code_t       r_code;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ST_IDLE;
        r_hold  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_hold  <= w_hold_nxt;
      end
    end

    // A release wins over a tick arriving in the same cycle.
    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_post      = 1'b0;
      w_post_code = EV_PRESS;
      case (r_state)
        ST_IDLE: begin
          if (w_rise[gi]) begin
            w_post      = 1'b1;
            w_post_code = EV_PRESS;
            w_state_nxt = ST_SHORT;
            w_hold_nxt  = '0;
          end
        end
        ST_SHORT: begin
          if (w_fall[gi]) begin
            w_post      = 1'b1;
            w_post_code = EV_RELEASE;
            w_state_nxt = ST_IDLE;
          end else if (w_tick) begin
            if (r_hold == HOLD_W'(LONG_PRESS_TICKS - 1)) begin
              w_post      = 1'b1;
              w_post_code = EV_LONG;
              w_state_nxt = ST_LONG;
              w_hold_nxt  = '0;
            end else begin
              w_hold_nxt = r_hold + HOLD_W'(1);
            end
          end
        end
        ST_LONG: begin
          if (w_fall[gi]) begin
            w_post      = 1'b1;
            w_post_code = EV_RELEASE;
            w_state_nxt = ST_IDLE;
          end else if (w_tick) begin
            if (r_hold == HOLD_W'(REPEAT_TICKS - 1)) begin
              w_post      = 1'b1;
              w_post_code = EV_REPEAT;
              w_hold_nxt  = '0;
            end else begin
              w_hold_nxt = r_hold + HOLD_W'(1);
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // Pending slot: a busy, undrained slot keeps its event and the new one is lost.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_v    <= 1'b0;
        r_code <= EV_PRESS;
      end else if (w_post && (!r_v || w_drain[gi])) begin
        r_v    <= 1'b1;
        r_code <= w_post_code;
      end else if (w_drain[gi]) begin
        r_v    <= 1'b0;
      end
    end

    assign w_drop[gi]      = w_post && r_v && !w_drain[gi];
    assign w_slot_v[gi]    = r_v;
    assign w_slot_code[gi] = r_code;
  end

  // Fixed-priority arbiter: lowest-index pending slot goes first.
  always_comb begin
    w_grant     = '0;
    w_any       = 1'b0;
    w_push_data = '0;
    for (int unsigned p = 0; p < PORT_BITS; p++) begin
      if (w_slot_v[p] && !w_any) begin
        w_grant[p]       = 1'b1;
        w_any            = 1'b1;
        w_push_data.code = w_slot_code[p];
        w_push_data.port = EVT_PORT_W'(p);
      end
    end
  end

  assign w_pop   = !w_empty && event_ready;
  assign w_push  = w_any && (!w_full || w_pop);
  assign w_drain = w_grant & {PORT_BITS{w_push}};

  button_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign event_valid   = !w_empty;
  assign event_code    = w_head.code;
  assign event_port    = w_head.port[PW-1:0];
  assign w_unused_port = ^w_head.port;

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            r_overflow <= 1'b0;
    else if (|w_drop)        r_overflow <= 1'b1;
    else if (overflow_clear) r_overflow <= 1'b0;
  end
  assign overflow = r_overflow;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: tick-counting event model plus directed scenarios
// with literal expected event logs.
module tb_button_event;

  localparam int unsigned CLK_HZ = 10_000;
  localparam int unsigned TK_HZ  = 1000;
  localparam int unsigned PB     = 2;
  localparam int          LPT    = 5;
  localparam int          RPT    = 3;
  localparam int          DIV    = 10;

  logic          clock;
  logic          reset_n;
  logic [PB-1:0] sync_in;
  logic [PB-1:0] pressed;
  logic          event_valid;
  logic          event_ready;
  logic [1:0]    event_code;
  logic [0:0]    event_port;
  logic          overflow;
  logic          overflow_clear;

  button_event #(
    .CLOCK_HZ         (CLK_HZ),
    .TICK_HZ          (TK_HZ),
    .PORT_BITS        (PB),
    .LONG_PRESS_TICKS (LPT),
    .REPEAT_TICKS     (RPT),
    .FIFO_DEPTH       (4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .sync_in        (sync_in),
    .pressed        (pressed),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_code     (event_code),
    .event_port     (event_port),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Events are encoded as code*10 + port.
  int            exp_q[$];
  int            log_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  bit            model_on;
  int            k;
  logic [PB-1:0] m_prev;
  int            m_n[PB];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_log(input string tag, input int ex[$]);
    chk({tag, "_count"}, log_q.size(), ex.size());
    foreach (ex[i]) chk(tag, (i < log_q.size()) ? log_q[i] : -1, ex[i]);
  endtask

  // Model: count ticks seen while held; LONG at tick LPT, REPEAT every RPT after.
  always @(posedge clock or negedge reset_n) begin : mdl
    bit t;
    if (!reset_n) begin
      k = 0;
      m_prev = '0;
      for (int i = 0; i < PB; i++) m_n[i] = 0;
      exp_q.delete();
    end else begin
      t = ((k % DIV) == 0);
      k++;
      for (int i = 0; i < PB; i++) begin
        if (sync_in[i] && !m_prev[i]) begin
          exp_q.push_back(i);
          m_n[i] = 0;
        end else if (!sync_in[i] && m_prev[i]) begin
          exp_q.push_back(10 + i);
        end else if (sync_in[i] && t) begin
          m_n[i]++;
          if (m_n[i] == LPT) exp_q.push_back(20 + i);
          else if (m_n[i] > LPT && ((m_n[i] - LPT) % RPT) == 0) exp_q.push_back(30 + i);
        end
      end
      m_prev = sync_in;
    end
  end

  // Compare process, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("pressed", int'(pressed), int'(m_prev));
      if (event_valid && event_ready) begin
        log_q.push_back(int'(event_code) * 10 + int'(event_port));
        if (model_on) begin
          chk("event", int'(event_code) * 10 + int'(event_port),
              (exp_q.size() == 0) ? -1 : exp_q[0]);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
      if (model_on) chk("overflow", int'(overflow), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int ex[$];
    int it;
    reset_n        = 1'b0;
    sync_in        = '0;
    event_ready    = 1'b1;
    overflow_clear = 1'b0;
    model_on       = 1'b1;
    step(3);
    chk("rst_valid", int'(event_valid), 0);
    chk("rst_code", int'(event_code), 0);
    chk("rst_port", int'(event_port), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_pressed", int'(pressed), 0);
    reset_n = 1'b1;
    step(5);

    // Short press on port 0 with latency check
    log_q.delete();
    sync_in[0] = 1'b1;
    step(1);
    chk("lat_e0_valid", int'(event_valid), 0);
    step(1);
    chk("lat_e1_valid", int'(event_valid), 1);
    chk("lat_e1_code", int'(event_code), 0);
    chk("lat_e1_port", int'(event_port), 0);
    step(18);
    sync_in[0] = 1'b0;
    step(6);
    ex = '{0, 10};
    check_log("short", ex);
    chk("short_q_empty", exp_q.size(), 0);

    // Long hold on port 1
    log_q.delete();
    sync_in[1] = 1'b1;
    step(120);
    sync_in[1] = 1'b0;
    step(6);
    ex = '{1, 21, 31, 31, 11};
    check_log("long", ex);
    chk("long_q_empty", exp_q.size(), 0);

    // Simultaneous press on both ports
    log_q.delete();
    sync_in = 2'b11;
    step(2);
    chk("sim_e1_valid", int'(event_valid), 1);
    chk("sim_e1_ev", int'(event_code) * 10 + int'(event_port), 0);
    step(1);
    chk("sim_e2_valid", int'(event_valid), 1);
    chk("sim_e2_ev", int'(event_code) * 10 + int'(event_port), 1);
    step(8);
    sync_in = 2'b00;
    step(6);
    ex = '{0, 1, 10, 11};
    check_log("sim", ex);
    chk("sim_q_empty", exp_q.size(), 0);

    // Backpressure: fill FIFO, fill slots, then drop
    model_on    = 1'b0;
    event_ready = 1'b0;
    log_q.delete();
    sync_in = 2'b11;
    step(3);
    sync_in = 2'b00;
    step(3);
    sync_in = 2'b11;
    step(3);
    chk("bp_no_drop_yet", int'(overflow), 0);
    sync_in = 2'b00;
    step(2);
    chk("bp_overflow_set", int'(overflow), 1);
    chk("bp_valid", int'(event_valid), 1);
    chk("bp_head", int'(event_code) * 10 + int'(event_port), 0);
    step(3);
    chk("bp_head_stable", int'(event_code) * 10 + int'(event_port), 0);
    chk("bp_overflow_sticky", int'(overflow), 1);
    event_ready = 1'b1;
    step(10);
    ex = '{0, 1, 10, 11, 0, 1};
    check_log("bp", ex);
    chk("bp_drained", int'(event_valid), 0);
    chk("bp_overflow_kept", int'(overflow), 1);
    overflow_clear = 1'b1;
    step(1);
    overflow_clear = 1'b0;
    chk("bp_overflow_cleared", int'(overflow), 0);
    exp_q.delete();
    model_on = 1'b1;
    step(2);

    // Release coinciding with the tick that would issue LONG
    log_q.delete();
    sync_in[0] = 1'b1;
    it = 0;
    while (it < 100 && !(m_n[0] == LPT - 1 && (k % DIV) == 0)) begin
      step(1);
      it++;
    end
    chk("rot_aligned", m_n[0], LPT - 1);
    sync_in[0] = 1'b0;
    step(6);
    ex = '{0, 10};
    check_log("rot", ex);
    chk("rot_q_empty", exp_q.size(), 0);

    // Reset while in LONG with an event waiting at the head
    log_q.delete();
    sync_in[1] = 1'b1;
    step(30);
    event_ready = 1'b0;
    step(35);
    chk("mid_valid_before", int'(event_valid), 1);
    chk("mid_head_long", int'(event_code) * 10 + int'(event_port), 21);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(event_valid), 0);
    chk("mid_rst_pressed", int'(pressed), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    step(2);
    event_ready = 1'b1;
    log_q.delete();
    reset_n = 1'b1;
    step(12);
    sync_in[1] = 1'b0;
    step(6);
    ex = '{1, 11};
    check_log("mid", ex);
    chk("mid_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the debounced, clock-synchronous switch levels produced by the debounce filter.
- Turns each level into discrete key events: PRESS, RELEASE, LONG (long press) and REPEAT (auto-repeat while held).
- Events from all ports are serialized into one valid/ready stream through a small FIFO, for a CPU register block or a UI controller.

Parameters:
- CLOCK_HZ, 12_000_000: clock frequency.
- TICK_HZ, 1000: timing tick rate; one tick equals one time unit of the hold counters.
- PORT_BITS, 1: number of switch inputs.
- LONG_PRESS_TICKS, 500: ticks held before LONG is issued; must be >= 2.
- REPEAT_TICKS, 100: ticks between REPEAT events after LONG; must be >= 2.
- FIFO_DEPTH, 4: output event FIFO entries; power of 2.

Ports:
- clock, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- sync_in, input, PORT_BITS: debounced levels; 1 = pressed; already synchronous to clock.
- pressed, output, PORT_BITS: registered copy of sync_in.
- event_valid, output, 1: FIFO head valid.
- event_ready, input, 1: consumer accepts the head when valid && ready.
- event_code, output, 2: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
- event_port, output, max(1,$clog2(PORT_BITS)): index of the source port.
- overflow, output, 1: sticky flag; set when an event is dropped.
- overflow_clear, input, 1: synchronous clear of overflow.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs are 0, all FSMs are IDLE, counters are 0, the FIFO is empty and pending slots are clear.
- Tick divider: counts 0..CLOCK_HZ/TICK_HZ-1 and wraps. tick = (count == 0). With CLOCK_HZ == TICK_HZ, tick is asserted every cycle.
- Edge detection: prev[i] <= sync_in[i]; pressed = prev.
  - rise = sync_in & ~prev.
  - fall = ~sync_in & prev.
- Per-port FSM, states IDLE / SHORT / LONG, with a hold counter wide enough for max(LONG_PRESS_TICKS, REPEAT_TICKS):
  - IDLE, on rise: post PRESS, go to SHORT, hold = 0.
  - SHORT, on tick: if hold == LONG_PRESS_TICKS-1, post LONG, go to LONG, hold = 0; otherwise hold++.
  - LONG, on tick: if hold == REPEAT_TICKS-1, post REPEAT, hold = 0; otherwise hold++. REPEAT continues indefinitely while held.
  - SHORT or LONG, on fall: post RELEASE, go to IDLE. fall has priority over a same-cycle tick, so no LONG/REPEAT is posted on that cycle.
- Pending slot: one slot per port, holding a valid bit and a 2-bit code.
  - "Post" loads the slot in the cycle the edge or tick is sampled.
  - If the slot is already valid and not being drained this cycle, the new event is dropped and overflow is set. Slot contents stay unchanged.
  - A slot drained and posted in the same cycle accepts the new event.
- Arbiter: each cycle, picks the lowest-index valid slot and writes {code, port} into the FIFO if the FIFO is not full or is being popped that cycle. A successful write clears that slot. When the FIFO is full and no pop occurs, slots hold their events (no drop at this stage).
- FIFO: show-ahead.
  - event_valid = not empty; event_code and event_port reflect the head.
  - Pop on event_valid && event_ready.
  - Push and pop in the same cycle are allowed at full and at empty.
  - event_code and event_port are held stable while valid && !ready.
- Latency: sync_in rises, sampled at clock edge E0, which loads the slot. FIFO write happens at E1, so event_valid is high after E1 (2 cycles, empty FIFO, no contention).
- overflow: cleared by overflow_clear. A set and a clear in the same cycle leave overflow set.
- A press shorter than LONG_PRESS_TICKS produces exactly PRESS then RELEASE.
- Ticks are free-running, so the first LONG arrives between LONG_PRESS_TICKS-1 and LONG_PRESS_TICKS tick periods after PRESS.

Decomposition:
- Package button_event_pkg:
  - event_code_t enum: PRESS, RELEASE, LONG, REPEAT.
  - btn_state_t enum: IDLE, SHORT, LONG.
  - Packed struct event_t: {code, port}.
- Sub-module button_event_fifo: synchronous show-ahead FIFO of event_t, with parameter DEPTH and push/pop/full/empty.
- The FSM, slots and arbiter live in the top module in a generate loop.

Test Plan:
Test parameters: CLOCK_HZ=10_000, TICK_HZ=1000 (10 clocks per tick), PORT_BITS=2, LONG_PRESS_TICKS=5, REPEAT_TICKS=3, FIFO_DEPTH=4, event_ready=1 unless stated.
- Short press: sync_in[0] high for 20 cycles -> (PRESS, 0), then (RELEASE, 0). First event_valid appears 2 cycles after the rise; no LONG.
- Long hold: sync_in[1] held for 120 cycles -> PRESS, LONG about 50 cycles later, REPEAT every 30 cycles (2 REPEATs), then RELEASE; all with port 1.
- Simultaneous: both ports rise on the same cycle -> (PRESS, 0) then (PRESS, 1) on consecutive valid beats.
- Backpressure: event_ready=0 with 6 events generated across 2 ports -> 4 buffered, 1 per port held in slots, further posts set overflow. Then event_ready=1 -> events drain in order; overflow_clear -> overflow 0.
- Release on tick: fall coincides with the tick at hold == LONG_PRESS_TICKS-1 -> RELEASE only; no LONG.
- Reset mid-hold: reset_n low in LONG state -> event_valid=0, pressed=0, overflow=0 immediately. After release of reset with the input still high -> a fresh PRESS.
